// File: rtl/counter_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : counter_seq_ctrl
// Purpose  : Two-port round-robin job sequencer driving a shared up/down
//            loadable counter through load / run / done phases.
// Revision : 1.0 - initial release
// ============================================================================
module counter_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_start,
    input  logic [WIDTH-1:0] req0_stop,
    input  logic             req0_dir,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_start,
    input  logic [WIDTH-1:0] req1_stop,
    input  logic             req1_dir,
    input  logic             abort,
    output logic             cnt_load,
    output logic [WIDTH-1:0] cnt_data,
    output logic             cnt_up_down,
    output logic             cnt_en,
    input  logic [WIDTH-1:0] cnt_count,
    output logic             busy,
    output logic             done_valid,
    output logic             done_id,
    output logic             done_abort
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             r_last_grant;
    logic [WIDTH-1:0] r_start;
    logic [WIDTH-1:0] r_stop;
    logic             r_dir;
    logic             r_id;
    logic             r_abort;

    logic             w_grant0;
    logic             w_grant1;
    logic             w_accept;
    logic             w_set_abort;

    // With both requesting, the one not served most recently wins.
    assign w_grant0   = req0_valid && (!req1_valid || r_last_grant);
    assign w_grant1   = req1_valid && (!req0_valid || !r_last_grant);
    assign req0_ready = !reset && (r_state == ST_IDLE) && w_grant0;
    assign req1_ready = !reset && (r_state == ST_IDLE) && w_grant1;
    assign w_accept   = req0_ready || req1_ready;

    assign busy       = (r_state != ST_IDLE);
    assign done_valid = (r_state == ST_DONE);
    assign done_id    = done_valid && r_id;
    assign done_abort = done_valid && r_abort;

    always_comb begin
        w_next_state = r_state;
        w_set_abort  = 1'b0;
        cnt_load     = 1'b0;
        cnt_en       = 1'b0;
        cnt_data     = '0;
        cnt_up_down  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_data    = r_start;
                cnt_up_down = r_dir;
                cnt_load    = !abort;
                if (abort) begin
                    w_next_state = ST_DONE;
                    w_set_abort  = 1'b1;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_up_down = r_dir;
                cnt_en      = (cnt_count != r_stop) && !abort;
                if (abort) begin
                    w_next_state = ST_DONE;
                    w_set_abort  = 1'b1;
                end else if (cnt_count == r_stop) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_start      <= '0;
            r_stop       <= '0;
            r_dir        <= 1'b0;
            r_id         <= 1'b0;
            r_abort      <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_start      <= req1_ready ? req1_start : req0_start;
                r_stop       <= req1_ready ? req1_stop  : req0_stop;
                r_dir        <= req1_ready ? req1_dir   : req0_dir;
                r_id         <= req1_ready;
                r_last_grant <= req1_ready;
                r_abort      <= 1'b0;
            end
            if (w_set_abort) begin
                r_abort <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_counter_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_seq_ctrl
// Purpose  : Self-checking bench for counter_seq_ctrl with a counter stand-in.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [3:0] req0_start = '0, req0_stop = '0, req1_start = '0, req1_stop = '0;
    logic       req0_dir = 1'b0, req1_dir = 1'b0;
    logic       abort = 1'b0;
    logic       cnt_load, cnt_up_down, cnt_en;
    logic [3:0] cnt_data;
    logic [3:0] cnt_count = 4'd0;
    logic       busy, done_valid, done_id, done_abort;

    int total = 0;
    int bad   = 0;
    int m_last = 1;

    int         o_lat, o_ens, o_id;
    logic       o_hs, o_done, o_did, o_dab, o_load, o_ud, o_both, o_en_abort;
    logic [3:0] o_data, o_cnt_done;

    counter_seq_ctrl #(.WIDTH(4)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_start(req0_start),
        .req0_stop(req0_stop), .req0_dir(req0_dir),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_start(req1_start),
        .req1_stop(req1_stop), .req1_dir(req1_dir),
        .abort(abort), .cnt_load(cnt_load), .cnt_data(cnt_data),
        .cnt_up_down(cnt_up_down), .cnt_en(cnt_en), .cnt_count(cnt_count),
        .busy(busy), .done_valid(done_valid), .done_id(done_id), .done_abort(done_abort)
    );

    always #5 clk = ~clk;

    // Stand-in for the shared counter: load wins over count, wraps mod 16.
    always @(posedge clk) begin
        if (cnt_load)
            cnt_count <= cnt_data;
        else if (cnt_en)
            cnt_count <= cnt_up_down ? cnt_count + 4'd1 : cnt_count - 4'd1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int steps(input logic [3:0] s, input logic [3:0] p, input logic d);
        logic [3:0] diff;
        diff = d ? (p - s) : (s - p);
        return int'(diff);
    endfunction

    function automatic int pick_winner(input logic v0, input logic v1);
        if (v0 && v1) return (m_last == 1) ? 0 : 1;
        return v0 ? 0 : 1;
    endfunction

    function automatic int exp_lat(input int n, input int a);
        if (a >= 1 && a <= 2 + n) return a + 1;
        return 3 + n;
    endfunction

    function automatic int exp_ens(input int n, input int a);
        if (a >= 1 && a <= 2 + n) return (a >= 2) ? a - 2 : 0;
        return n;
    endfunction

    function automatic logic [3:0] exp_cnt(input logic [3:0] s, input logic [3:0] p,
                                           input logic d, input int n, input int a);
        logic [3:0] off;
        if (a >= 2 && a <= 2 + n) begin
            off = 4'(a - 2);
            return d ? s + off : s - off;
        end
        return p;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        reset = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        abort = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_last = 1;
    endtask

    // Offers a job on the selected ports, then follows it to completion,
    // recording what the DUT did. abort_at: 0 = none, 1 = LOAD cycle, k = k-th cycle after c0.
    task automatic do_job(input logic v0, input logic [3:0] s0, input logic [3:0] p0, input logic d0,
                          input logic v1, input logic [3:0] s1, input logic [3:0] p1, input logic d1,
                          input int abort_at);
        int w;
        int k;
        o_hs = 0; o_done = 0; o_lat = -1; o_ens = 0; o_id = -1; o_did = 0; o_dab = 0;
        o_load = 0; o_ud = 0; o_data = 0; o_cnt_done = 0; o_both = 0; o_en_abort = 1;
        req0_valid = v0; req0_start = s0; req0_stop = p0; req0_dir = d0;
        req1_valid = v1; req1_start = s1; req1_stop = p1; req1_dir = d1;
        w = 0;
        #1;
        while (!o_hs && w < 20) begin
            if (req0_ready && req1_ready) o_both = 1;
            if (req0_valid && req0_ready) begin o_hs = 1; o_id = 0; end
            else if (req1_valid && req1_ready) begin o_hs = 1; o_id = 1; end
            @(posedge clk); #1;
            w++;
        end
        req0_valid = 0;
        req1_valid = 0;
        k = 1;
        while (o_hs && !o_done && k <= 40) begin
            abort = (k == abort_at);
            #1;
            if (k == 1) begin o_load = cnt_load; o_data = cnt_data; o_ud = cnt_up_down; end
            if (abort && (cnt_en || cnt_load)) o_en_abort = 0;
            if (cnt_en) o_ens++;
            if (done_valid) begin
                o_done = 1; o_lat = k; o_did = done_id; o_dab = done_abort; o_cnt_done = cnt_count;
            end
            @(posedge clk); #1;
            k++;
        end
        abort = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        @(posedge clk); #1;
        total++;
        if ((req0_ready | req1_ready) !== 1'b0) begin
            bad++; $display("FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        reset = 1'b0;
        m_last = 1;
        #1;
        total++;
        if ({busy, done_valid, done_id, done_abort} !== 4'b0000) begin
            bad++; $display("FAIL reset_status: got %b want 0000", {busy, done_valid, done_id, done_abort});
        end
        total++;
        if ({cnt_load, cnt_en, cnt_up_down, cnt_data} !== 7'd0) begin
            bad++; $display("FAIL reset_cnt_ctrl: got %b want 0000000", {cnt_load, cnt_en, cnt_up_down, cnt_data});
        end
    endtask

    task automatic test_up_basic();
        do_job(1, 4'd3, 4'd7, 1, 0, 4'd0, 4'd0, 0, 0);
        m_last = 0;
        total++;
        if (!(o_load === 1'b1 && o_data === 4'd3 && o_ud === 1'b1)) begin
            bad++; $display("FAIL up_load: got load=%b data=%0d ud=%b want 1 3 1", o_load, o_data, o_ud);
        end
        total++;
        if (o_ens !== steps(4'd3, 4'd7, 1'b1)) begin
            bad++; $display("FAIL up_en_cycles: got %0d want %0d", o_ens, steps(4'd3, 4'd7, 1'b1));
        end
        total++;
        if (o_lat !== 7 || o_did !== 1'b0 || o_dab !== 1'b0 || o_cnt_done !== 4'd7) begin
            bad++; $display("FAIL up_done: got lat=%0d id=%b ab=%b cnt=%0d want 7 0 0 7", o_lat, o_did, o_dab, o_cnt_done);
        end
    endtask

    task automatic test_down_wrap();
        do_job(0, 4'd0, 4'd0, 0, 1, 4'd1, 4'd14, 0, 0);
        m_last = 1;
        total++;
        if (o_ens !== 3) begin
            bad++; $display("FAIL down_en_cycles: got %0d want 3", o_ens);
        end
        total++;
        if (o_lat !== 6 || o_did !== 1'b1 || o_cnt_done !== 4'd14 || o_ud !== 1'b0) begin
            bad++; $display("FAIL down_done: got lat=%0d id=%b cnt=%0d ud=%b want 6 1 14 0", o_lat, o_did, o_cnt_done, o_ud);
        end
    endtask

    task automatic test_equal();
        do_job(1, 4'd9, 4'd9, 1, 0, 4'd0, 4'd0, 0, 0);
        m_last = 0;
        total++;
        if (o_ens !== 0) begin
            bad++; $display("FAIL equal_en: got %0d want 0", o_ens);
        end
        total++;
        if (o_lat !== 3 || o_dab !== 1'b0) begin
            bad++; $display("FAIL equal_done: got lat=%0d ab=%b want 3 0", o_lat, o_dab);
        end
    endtask

    task automatic test_back_to_back();
        int q[$];
        int w;
        int both;
        int e;
        do_reset();
        req0_start = 4'd5; req0_stop = 4'd5; req0_dir = 1;
        req1_start = 4'd6; req1_stop = 4'd6; req1_dir = 0;
        req0_valid = 1; req1_valid = 1;
        w = 0; both = 0;
        while (q.size() < 3 && w < 40) begin
            #1;
            if (req0_ready && req1_ready) both++;
            if (req0_ready) q.push_back(0);
            else if (req1_ready) q.push_back(1);
            @(posedge clk); #1;
            w++;
        end
        req0_valid = 0; req1_valid = 0;
        repeat (6) @(posedge clk);
        #1;
        total++;
        if (both !== 0) begin
            bad++; $display("FAIL b2b_both_ready: got %0d cycles want 0", both);
        end
        total++;
        if (q.size() !== 3) begin
            bad++; $display("FAIL b2b_grant_count: got %0d want 3", q.size());
        end
        for (int i = 0; i < 3; i++) begin
            e = pick_winner(1, 1);
            m_last = e;
            if (i < q.size()) begin
                total++;
                if (q[i] !== e) begin
                    bad++; $display("FAIL b2b_grant%0d: got %0d want %0d", i, q[i], e);
                end
            end
        end
    endtask

    task automatic test_abort();
        do_job(1, 4'd0, 4'd15, 1, 0, 4'd0, 4'd0, 0, 4);
        m_last = 0;
        total++;
        if (o_en_abort !== 1'b1) begin
            bad++; $display("FAIL abort_en_gate: got %b want 1", o_en_abort);
        end
        total++;
        if (o_lat !== 5 || o_dab !== 1'b1 || o_ens !== 2) begin
            bad++; $display("FAIL abort_done: got lat=%0d ab=%b ens=%0d want 5 1 2", o_lat, o_dab, o_ens);
        end
        total++;
        if (o_cnt_done !== 4'd2 || cnt_count !== 4'd2) begin
            bad++; $display("FAIL abort_frozen: got %0d/%0d want 2", o_cnt_done, cnt_count);
        end
    endtask

    task automatic test_reset_mid_job();
        int w;
        int dv;
        req0_start = 4'd2; req0_stop = 4'd12; req0_dir = 1; req0_valid = 1;
        w = 0;
        #1;
        while (!req0_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        @(posedge clk); #1;
        req0_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        m_last = 1;
        #1;
        total++;
        if ({busy, cnt_en, cnt_load, done_valid} !== 4'b0000) begin
            bad++; $display("FAIL midreset_idle: got %b want 0000", {busy, cnt_en, cnt_load, done_valid});
        end
        dv = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (done_valid || busy) dv++;
        end
        total++;
        if (dv !== 0) begin
            bad++; $display("FAIL midreset_quiet: got %0d active cycles want 0", dv);
        end
        do_job(0, 4'd0, 4'd0, 0, 1, 4'd5, 4'd8, 1, 0);
        m_last = 1;
        total++;
        if (o_id !== 1 || o_lat !== 6 || o_did !== 1'b1 || o_dab !== 1'b0 || o_cnt_done !== 4'd8) begin
            bad++; $display("FAIL midreset_next_job: got id=%0d lat=%0d did=%b ab=%b cnt=%0d want 1 6 1 0 8",
                            o_id, o_lat, o_did, o_dab, o_cnt_done);
        end
    endtask

    task automatic test_random();
        logic       v0, v1, d0, d1, wd;
        logic [3:0] s0, p0, s1, p1, ws, wp;
        int         sel, win, n, a;
        for (int it = 0; it < 16; it++) begin
            sel = $urandom_range(1, 3);
            v0 = sel[0]; v1 = sel[1];
            s0 = 4'($urandom); p0 = 4'($urandom); d0 = 1'($urandom);
            s1 = 4'($urandom); p1 = 4'($urandom); d1 = 1'($urandom);
            win = pick_winner(v0, v1);
            ws = win ? s1 : s0; wp = win ? p1 : p0; wd = win ? d1 : d0;
            n = steps(ws, wp, wd);
            a = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2 + n) : 0;
            do_job(v0, s0, p0, d0, v1, s1, p1, d1, a);
            m_last = win;
            total++;
            if (o_id !== win || o_did !== 1'(win) || o_both !== 1'b0) begin
                bad++; $display("FAIL rnd%0d_grant: got id=%0d did=%b both=%b want %0d", it, o_id, o_did, o_both, win);
            end
            total++;
            if (o_lat !== exp_lat(n, a) || o_ens !== exp_ens(n, a) || o_dab !== (a != 0)) begin
                bad++; $display("FAIL rnd%0d_timing: got lat=%0d ens=%0d ab=%b want %0d %0d %b",
                                it, o_lat, o_ens, o_dab, exp_lat(n, a), exp_ens(n, a), (a != 0));
            end
            total++;
            if (o_load !== (a != 1) || o_en_abort !== 1'b1 || (a != 1 && o_data !== ws) || o_ud !== wd) begin
                bad++; $display("FAIL rnd%0d_load: got load=%b data=%0d ud=%b gate=%b want %b %0d %b 1",
                                it, o_load, o_data, o_ud, o_en_abort, (a != 1), ws, wd);
            end
            if (a != 1) begin
                total++;
                if (o_cnt_done !== exp_cnt(ws, wp, wd, n, a)) begin
                    bad++; $display("FAIL rnd%0d_count: got %0d want %0d", it, o_cnt_done, exp_cnt(ws, wp, wd, n, a));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_up_basic();
        test_down_wrap();
        test_equal();
        test_back_to_back();
        test_abort();
        test_reset_mid_job();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
